// File: rtl/ball_engine_if.sv
// ball_engine_if: frame/serve/paddle inputs and ball/score outputs of the Pong game-state engine.
// Latency: none; this is a wiring bundle only.
// Backpressure: none; every signal is a level or a single-cycle pulse.
// Ports (master drives / slave drives):
//   master -> slave : frame_tick, serve, left_paddle[9:0], right_paddle[9:0]
//   slave -> master : ball_x[9:0], ball_y[9:0], score_left[3:0], score_right[3:0],
//                     score_left_pulse, score_right_pulse, in_play, game_over
interface ball_engine_if;
  logic       frame_tick;
  logic       serve;
  logic [9:0] left_paddle;
  logic [9:0] right_paddle;
  logic [9:0] ball_x;
  logic [9:0] ball_y;
  logic [3:0] score_left;
  logic [3:0] score_right;
  logic       score_left_pulse;
  logic       score_right_pulse;
  logic       in_play;
  logic       game_over;

  modport master (
    output frame_tick, serve, left_paddle, right_paddle,
    input  ball_x, ball_y, score_left, score_right,
    input  score_left_pulse, score_right_pulse, in_play, game_over
  );

  modport slave (
    input  frame_tick, serve, left_paddle, right_paddle,
    output ball_x, ball_y, score_left, score_right,
    output score_left_pulse, score_right_pulse, in_play, game_over
  );
endinterface

// File: rtl/ball_engine.sv
// ball_engine: Pong game state (ball position/direction/speed, scores, serve/play FSM).
// Latency: one cycle; all outputs are registered and update on the edge that samples frame_tick/serve.
// Backpressure: none; frame_tick and serve are consumed when sampled and are never stalled.
// Ports:
//   clk            pixel clock
//   rst            asynchronous active-high reset
//   bus (slave)    frame_tick, serve, left_paddle, right_paddle in;
//                  ball_x, ball_y, score_left/right, score_left/right_pulse, in_play, game_over out
// Optional feature: define BALL_SPEEDUP_EN to raise the ball speed by one per paddle hit,
// saturating at MAX_SPEED; the speed drops back to BALL_SPEED on every score and on a new game.
module ball_engine #(
  parameter int LEFT_BOUNDARY   = 3,
  parameter int RIGHT_BOUNDARY  = 637,
  parameter int TOP_BOUNDARY    = 3,
  parameter int BOTTOM_BOUNDARY = 477,
  parameter int PLAYER_PADDLE_X = 10,
  parameter int AI_PADDLE_X     = 620,
  parameter int PADDLE_WIDTH    = 10,
  parameter int PADDLE_HEIGHT   = 46,
  parameter int BALL_SIZE       = 10,
  parameter int BALL_SPEED      = 2,
  parameter int MAX_SPEED       = 6,
  parameter int START_X         = 315,
  parameter int START_Y         = 235,
  parameter int SERVE_DELAY     = 60,
  parameter int WIN_SCORE       = 9
) (
  input logic         clk,
  input logic         rst,
  ball_engine_if.slave bus
);

  // Speed must let the ball land inside a paddle face window on some frame.
  localparam bit CFG_OK = (BALL_SPEED >= 1) && (BALL_SPEED <= PADDLE_WIDTH) &&
                          (MAX_SPEED >= BALL_SPEED) && (MAX_SPEED <= PADDLE_WIDTH);
  if (!CFG_OK) begin : g_bad_cfg
    $error("ball_engine: BALL_SPEED/MAX_SPEED must lie in 1..PADDLE_WIDTH");
  end

  // 11-bit comparison constants: one spare bit so no sum below can wrap.
  localparam logic [10:0] LB      = 11'(LEFT_BOUNDARY);
  localparam logic [10:0] RB      = 11'(RIGHT_BOUNDARY);
  localparam logic [10:0] TB      = 11'(TOP_BOUNDARY);
  localparam logic [10:0] BB      = 11'(BOTTOM_BOUNDARY);
  localparam logic [10:0] BS      = 11'(BALL_SIZE);
  localparam logic [10:0] PH      = 11'(PADDLE_HEIGHT);
  localparam logic [10:0] FACE_L  = 11'(PLAYER_PADDLE_X + PADDLE_WIDTH);
  localparam logic [10:0] FACE_R  = 11'(AI_PADDLE_X);
  localparam logic [10:0] SPD_INIT = 11'(BALL_SPEED);

  // Positions the ball snaps to on a bounce or serve.
  localparam logic [9:0] X_START   = 10'(START_X);
  localparam logic [9:0] Y_START   = 10'(START_Y);
  localparam logic [9:0] X_LEFT_R  = 10'(PLAYER_PADDLE_X + PADDLE_WIDTH);
  localparam logic [9:0] X_RIGHT_R = 10'(AI_PADDLE_X - BALL_SIZE);
  localparam logic [9:0] Y_TOP_R   = 10'(TOP_BOUNDARY);
  localparam logic [9:0] Y_BOT_R   = 10'(BOTTOM_BOUNDARY - BALL_SIZE);

  localparam logic [3:0]  WIN   = 4'(WIN_SCORE);
  localparam logic [15:0] DELAY = 16'(SERVE_DELAY);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SERVE_WAIT,
    ST_PLAY,
    ST_GAME_OVER
  } state_t;

  state_t      state;
  logic [9:0]  bx, by;
  logic        dir_right, dir_down;
  logic [15:0] cnt;
  logic [3:0]  score_l, score_r;
  logic        pulse_l, pulse_r;
  logic        in_play_q, game_over_q;

`ifdef BALL_SPEEDUP_EN
  localparam logic [10:0] SPD_MAX = 11'(MAX_SPEED);
  logic [10:0] spd;
`else
  logic [10:0] spd;
  assign spd = SPD_INIT;
`endif

  // Collision and boundary tests on the current (pre-update) position.
  logic [10:0] x11, y11, r11, lp11, rp11;
  logic        ovl_l, ovl_r;
  logic        hit_l, hit_r, miss_l, miss_r;
  logic        bounce_bot, bounce_top;
  logic [9:0]  x_next, y_next;
  logic [3:0]  score_l_inc, score_r_inc;

  assign x11  = {1'b0, bx};
  assign y11  = {1'b0, by};
  assign r11  = x11 + BS;
  assign lp11 = {1'b0, bus.left_paddle};
  assign rp11 = {1'b0, bus.right_paddle};

  assign ovl_l = (y11 + BS > lp11) && (y11 < lp11 + PH);
  assign ovl_r = (y11 + BS > rp11) && (y11 < rp11 + PH);

  assign hit_l  = !dir_right && (x11 >= FACE_L) && (x11 <= FACE_L + spd) && ovl_l;
  assign miss_l = !dir_right && !hit_l && (x11 <= LB + spd);   // right player scores
  assign hit_r  = dir_right && (r11 <= FACE_R) && (r11 + spd >= FACE_R) && ovl_r;
  assign miss_r = dir_right && !hit_r && (r11 + spd >= RB);    // left player scores

  assign bounce_bot = dir_down && (y11 + BS + spd >= BB);
  assign bounce_top = !dir_down && (y11 <= TB + spd);

  always_comb begin
    x_next = bx;
    if (hit_l)          x_next = X_LEFT_R;
    else if (hit_r)     x_next = X_RIGHT_R;
    else if (dir_right) x_next = bx + spd[9:0];
    else                x_next = bx - spd[9:0];

    y_next = by;
    if (bounce_bot)     y_next = Y_BOT_R;
    else if (bounce_top) y_next = Y_TOP_R;
    else if (dir_down)  y_next = by + spd[9:0];
    else                y_next = by - spd[9:0];
  end

  // Scores saturate at WIN even though reaching WIN already stops play.
  assign score_l_inc = (score_l < WIN) ? score_l + 4'd1 : score_l;
  assign score_r_inc = (score_r < WIN) ? score_r + 4'd1 : score_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      bx          <= X_START;
      by          <= Y_START;
      dir_right   <= 1'b1;
      dir_down    <= 1'b1;
      cnt         <= DELAY;
      score_l     <= 4'd0;
      score_r     <= 4'd0;
      pulse_l     <= 1'b0;
      pulse_r     <= 1'b0;
      in_play_q   <= 1'b0;
      game_over_q <= 1'b0;
`ifdef BALL_SPEEDUP_EN
      spd         <= SPD_INIT;
`endif
    end else begin
      pulse_l <= 1'b0;
      pulse_r <= 1'b0;
      case (state)
        ST_IDLE: begin
          // A frame_tick arriving with serve is not counted toward the delay.
          if (bus.serve) begin
            state <= ST_SERVE_WAIT;
            cnt   <= DELAY;
          end
        end

        ST_SERVE_WAIT: begin
          if (bus.frame_tick) begin
            if (cnt == 16'd0) begin
              state     <= ST_PLAY;
              in_play_q <= 1'b1;
            end else begin
              cnt <= cnt - 16'd1;
            end
          end
        end

        ST_PLAY: begin
          if (bus.frame_tick) begin
            if (miss_l || miss_r) begin
              // Recentre and serve toward whoever conceded; Y update is skipped.
              bx        <= X_START;
              by        <= Y_START;
              dir_right <= miss_r;
              dir_down  <= 1'b1;
              in_play_q <= 1'b0;
`ifdef BALL_SPEEDUP_EN
              spd       <= SPD_INIT;
`endif
              if (miss_r) begin
                score_l <= score_l_inc;
                pulse_l <= 1'b1;
              end else begin
                score_r <= score_r_inc;
                pulse_r <= 1'b1;
              end
              if ((miss_r && score_l_inc == WIN) || (miss_l && score_r_inc == WIN)) begin
                state       <= ST_GAME_OVER;
                game_over_q <= 1'b1;
              end else begin
                state <= ST_SERVE_WAIT;
                cnt   <= DELAY;
              end
            end else begin
              bx <= x_next;
              by <= y_next;
              if (hit_l) dir_right <= 1'b1;
              if (hit_r) dir_right <= 1'b0;
              if (bounce_bot) dir_down <= 1'b0;
              if (bounce_top) dir_down <= 1'b1;
`ifdef BALL_SPEEDUP_EN
              if ((hit_l || hit_r) && (spd < SPD_MAX)) spd <= spd + 11'd1;
`endif
            end
          end
        end

        ST_GAME_OVER: begin
          if (bus.serve) begin
            state       <= ST_SERVE_WAIT;
            cnt         <= DELAY;
            score_l     <= 4'd0;
            score_r     <= 4'd0;
            game_over_q <= 1'b0;
`ifdef BALL_SPEEDUP_EN
            spd         <= SPD_INIT;
`endif
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.ball_x            = bx;
  assign bus.ball_y            = by;
  assign bus.score_left        = score_l;
  assign bus.score_right       = score_r;
  assign bus.score_left_pulse  = pulse_l;
  assign bus.score_right_pulse = pulse_r;
  assign bus.in_play           = in_play_q;
  assign bus.game_over         = game_over_q;

endmodule

// File: tb/tb_ball_engine.sv
// tb_ball_engine: randomized play of ball_engine against a frame-level reference model.
// Latency: model advances on the same edge as the DUT; outputs are compared 1 time unit later.
// Backpressure: none; the bench drives frame_tick/serve pulses freely.
module tb_ball_engine;

  localparam int SD    = 60;
  localparam int SPEED = 2;
  localparam int P_IDLE = 0, P_WAIT = 1, P_PLAY = 2, P_OVER = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ball_engine_if bus();
  ball_engine dut (.clk(clk), .rst(rst), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: plain integers, one update per sampled frame.
  int m_x, m_y, m_dx, m_dy, m_s, m_sl, m_sr, m_phase, m_wait;
  bit m_pl, m_pr;

  // Paddle behaviour knobs.
  int l_track = 0;
  int r_track = 100;
  bit l_avoid = 1'b0;

  function automatic void model_reset();
    m_x = 315; m_y = 235; m_dx = 1; m_dy = 1; m_s = SPEED;
    m_sl = 0; m_sr = 0; m_pl = 1'b0; m_pr = 1'b0; m_phase = P_IDLE; m_wait = 0;
  endfunction

  function automatic bit overlaps(int y, int py);
    return (y + 10 > py) && (y < py + 46);
  endfunction

  function automatic void model_move(int lp, int rp);
    int s;
    int scorer;  // 0 none, 1 left player, 2 right player
    bit hit;
    s = m_s; scorer = 0; hit = 1'b0;
    if (m_dx < 0) begin
      if (m_x >= 20 && m_x <= 20 + s && overlaps(m_y, lp)) begin
        m_x = 20; m_dx = 1; hit = 1'b1;
      end else if (m_x <= 3 + s) scorer = 2;
      else m_x = m_x - s;
    end else begin
      if (m_x + 10 <= 620 && m_x + 10 + s >= 620 && overlaps(m_y, rp)) begin
        m_x = 610; m_dx = -1; hit = 1'b1;
      end else if (m_x + 10 + s >= 637) scorer = 1;
      else m_x = m_x + s;
    end
    if (scorer != 0) begin
      m_x = 315; m_y = 235; m_dy = 1; m_s = SPEED;
      if (scorer == 1) begin m_sl++; m_pl = 1'b1; m_dx = 1; end
      else begin m_sr++; m_pr = 1'b1; m_dx = -1; end
      if (m_sl == 9 || m_sr == 9) m_phase = P_OVER;
      else begin m_phase = P_WAIT; m_wait = SD + 1; end
    end else begin
`ifdef BALL_SPEEDUP_EN
      if (hit) m_s = (m_s < 6) ? m_s + 1 : 6;
`endif
      if (m_dy > 0) begin
        if (m_y + 10 + s >= 477) begin m_y = 467; m_dy = -1; end
        else m_y = m_y + s;
      end else begin
        if (m_y <= 3 + s) begin m_y = 3; m_dy = 1; end
        else m_y = m_y - s;
      end
    end
  endfunction

  function automatic void model_step(bit t, bit sv, int lp, int rp);
    m_pl = 1'b0; m_pr = 1'b0;
    if (sv && m_phase == P_IDLE) begin
      m_phase = P_WAIT; m_wait = SD + 1;
    end else if (sv && m_phase == P_OVER) begin
      m_sl = 0; m_sr = 0; m_s = SPEED; m_phase = P_WAIT; m_wait = SD + 1;
    end else if (t && m_phase == P_WAIT) begin
      m_wait--;
      if (m_wait == 0) m_phase = P_PLAY;
    end else if (t && m_phase == P_PLAY) begin
      model_move(lp, rp);
    end
  endfunction

  function automatic logic [31:0] model_vec();
    return {10'(m_x), 10'(m_y), 4'(m_sl), 4'(m_sr), m_pl, m_pr,
            m_phase == P_PLAY, m_phase == P_OVER};
  endfunction

  logic [31:0] dut_vec;
  assign dut_vec = {bus.ball_x, bus.ball_y, bus.score_left, bus.score_right,
                    bus.score_left_pulse, bus.score_right_pulse, bus.in_play, bus.game_over};

  function automatic int pick(int pct, bit avoid);
    if (int'($urandom_range(99)) < pct) return (m_y > 18) ? m_y - 18 : 0;
    if (avoid) return (m_y > 200) ? 0 : 430;
    return int'($urandom_range(433));
  endfunction

  // One clock: drive at negedge, model follows the posedge, caller samples 1 unit later.
  task automatic step(input bit t, input bit sv);
    int lp, rp;
    @(negedge clk);
    lp = pick(l_track, l_avoid);
    rp = pick(r_track, 1'b0);
    bus.frame_tick   = t;
    bus.serve        = sv;
    bus.left_paddle  = 10'(lp);
    bus.right_paddle = 10'(rp);
    @(posedge clk);
    model_step(t, sv, lp, rp);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.frame_tick = 1'b0; bus.serve = 1'b0;
    bus.left_paddle = 10'd0; bus.right_paddle = 10'd0;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++; if (bus.ball_x !== 10'd315) begin n_fail++; $display("FAIL reset_ball_x got %0d exp 315", bus.ball_x); end
    n_checks++; if (bus.ball_y !== 10'd235) begin n_fail++; $display("FAIL reset_ball_y got %0d exp 235", bus.ball_y); end
    n_checks++; if ({bus.score_left, bus.score_right} !== 8'h00) begin n_fail++; $display("FAIL reset_scores got %0d/%0d exp 0/0", bus.score_left, bus.score_right); end
    n_checks++; if ({bus.score_left_pulse, bus.score_right_pulse, bus.in_play, bus.game_over} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_flags got %b exp 0000", {bus.score_left_pulse, bus.score_right_pulse, bus.in_play, bus.game_over}); end
  endtask

  task automatic test_idle_ignore();
    repeat (5) step(1'b1, 1'b0);
    n_checks++; if ({bus.ball_x, bus.ball_y} !== {10'd315, 10'd235}) begin
      n_fail++; $display("FAIL idle_ball got (%0d,%0d) exp (315,235)", bus.ball_x, bus.ball_y); end
    n_checks++; if (bus.in_play !== 1'b0) begin n_fail++; $display("FAIL idle_in_play got %b exp 0", bus.in_play); end
  endtask

  task automatic test_serve_delay();
    int n;
    step(1'b1, 1'b1);  // serve and tick together: tick is not counted
    n_checks++; if (bus.in_play !== 1'b0) begin n_fail++; $display("FAIL serve_wait_in_play got %b exp 0", bus.in_play); end
    n = 0;
    while (bus.in_play !== 1'b1 && n < 200) begin step(1'b1, 1'b0); n++; end
    n_checks++; if (n != SD + 1) begin n_fail++; $display("FAIL serve_delay_ticks got %0d exp %0d", n, SD + 1); end
    step(1'b1, 1'b0);
    n_checks++; if ({bus.ball_x, bus.ball_y} !== {10'd317, 10'd237}) begin
      n_fail++; $display("FAIL first_move got (%0d,%0d) exp (317,237)", bus.ball_x, bus.ball_y); end
  endtask

  task automatic test_random_play();
    l_track = 60; r_track = 70; l_avoid = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      step($urandom_range(2) == 0, $urandom_range(49) == 0);
      n_checks++;
      if (dut_vec !== model_vec()) begin
        n_fail++; $display("FAIL random_play cycle %0d got %h exp %h", i, dut_vec, model_vec());
      end
    end
  endtask

  task automatic test_reset_mid_play();
    int n;
    l_track = 100; r_track = 100; l_avoid = 1'b0;
    n = 0;
    while (m_phase != P_PLAY && n < 300) begin step(1'b1, 1'b1); n++; end
    n_checks++; if (bus.in_play !== 1'b1) begin n_fail++; $display("FAIL midplay_reach got in_play %b exp 1", bus.in_play); end
    repeat (7) step(1'b1, 1'b0);
    #2 rst = 1'b1;  // between clock edges
    #1;
    n_checks++; if ({bus.ball_x, bus.ball_y} !== {10'd315, 10'd235}) begin
      n_fail++; $display("FAIL async_reset_ball got (%0d,%0d) exp (315,235)", bus.ball_x, bus.ball_y); end
    n_checks++; if ({bus.score_left, bus.score_right, bus.in_play, bus.game_over} !== 10'd0) begin
      n_fail++; $display("FAIL async_reset_state got %0d/%0d/%b/%b exp 0/0/0/0", bus.score_left, bus.score_right, bus.in_play, bus.game_over); end
    model_reset();
    @(negedge clk);
    bus.frame_tick = 1'b0; bus.serve = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_win();
    int n;
    bit seen;
    l_track = 0; r_track = 100; l_avoid = 1'b1;
    step(1'b0, 1'b1);
    n = 0; seen = 1'b0;
    while (m_phase != P_OVER && n < 30000) begin
      step(1'b1, 1'b0);
      n++;
      n_checks++;
      if (dut_vec !== model_vec()) begin n_fail++; $display("FAIL win_play cycle %0d got %h exp %h", n, dut_vec, model_vec()); end
      if (!seen && m_pr) begin
        seen = 1'b1;
        n_checks++; if ({bus.score_right, bus.score_right_pulse, bus.in_play} !== {4'd1, 1'b1, 1'b0}) begin
          n_fail++; $display("FAIL first_miss got score %0d pulse %b in_play %b exp 1 1 0", bus.score_right, bus.score_right_pulse, bus.in_play); end
        n_checks++; if ({bus.ball_x, bus.ball_y} !== {10'd315, 10'd235}) begin
          n_fail++; $display("FAIL miss_recentre got (%0d,%0d) exp (315,235)", bus.ball_x, bus.ball_y); end
        step(1'b0, 1'b0);
        n_checks++; if (bus.score_right_pulse !== 1'b0) begin n_fail++; $display("FAIL pulse_width got %b exp 0", bus.score_right_pulse); end
      end
    end
    n_checks++; if (n >= 30000) begin n_fail++; $display("FAIL win_timeout after %0d cycles", n); end
    n_checks++; if ({bus.score_left, bus.score_right, bus.game_over, bus.in_play} !== {4'd0, 4'd9, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL win_state got %0d/%0d go %b ip %b exp 0/9 go 1 ip 0", bus.score_left, bus.score_right, bus.game_over, bus.in_play); end
    repeat (10) step(1'b1, 1'b0);
    n_checks++; if ({bus.ball_x, bus.ball_y, bus.score_right, bus.game_over} !== {10'd315, 10'd235, 4'd9, 1'b1}) begin
      n_fail++; $display("FAIL frozen got (%0d,%0d) score %0d go %b exp (315,235) 9 1", bus.ball_x, bus.ball_y, bus.score_right, bus.game_over); end
    step(1'b1, 1'b1);
    n_checks++; if ({bus.score_left, bus.score_right, bus.game_over, bus.in_play} !== 10'd0) begin
      n_fail++; $display("FAIL restart got %0d/%0d go %b ip %b exp 0/0 0 0", bus.score_left, bus.score_right, bus.game_over, bus.in_play); end
    n = 0;
    while (bus.in_play !== 1'b1 && n < 200) begin step(1'b1, 1'b0); n++; end
    n_checks++; if (n != SD + 1) begin n_fail++; $display("FAIL restart_delay got %0d exp %0d", n, SD + 1); end
    step(1'b1, 1'b0);
    n_checks++; if ({bus.ball_x, bus.ball_y} !== {10'd313, 10'd237}) begin
      n_fail++; $display("FAIL serve_left got (%0d,%0d) exp (313,237)", bus.ball_x, bus.ball_y); end
  endtask

  initial begin
    bus.frame_tick = 1'b0; bus.serve = 1'b0;
    bus.left_paddle = 10'd0; bus.right_paddle = 10'd0;
    model_reset();
    test_reset();
    test_idle_ignore();
    test_serve_delay();
    test_random_play();
    test_reset_mid_play();
    test_win();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog expired, checks %0d failures %0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
